pc_redirect_unit: RTL
=====================

# pc_redirect_unit

Fetch-side program-counter unit for the five-stage pipelined MIPS core: consumes the ID-stage branch decision from the branch comparator plus decoded jump information, computes the next fetch address, and holds the IF-stage PC register. Implements MIPS single-delay-slot semantics (the redirect lands after the delay-slot fetch), honours hazard stalls, flags misaligned register jumps, and keeps branch/taken statistics counters for performance debug.

## Interface

- RESET_PC, 32'h0000_3000, PC value loaded on reset
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; takes priority over every other input
- stall  in  1  hazard stall from the stall unit; freezes PC and counters this cycle
- is_branch_d  in  1  ID instruction is a conditional branch (beq/bne/bgezal)
- br_taken_d  in  1  comparator result for the ID instruction; ignored unless is_branch_d
- is_j_d  in  1  ID instruction is j/jal
- is_jr_d  in  1  ID instruction is jr/jalr
- pc4_d  in  32  PC+4 of the ID instruction
- imm16_d  in  16  branch offset field
- index26_d  in  26  jump index field
- jr_target_d  in  32  forwarded rs value for jr/jalr
- pc_f  out  32  current fetch address (registered)
- pc4_f  out  32  pc_f + 4 (combinational)
- link_d  out  32  pc4_d + 4, link address for jal/jalr/bgezal (combinational)
- redirect  out  1  combinational: next PC is not pc_f+4 this cycle (for trace/debug)
- addr_err  out  1  registered one-cycle pulse: misaligned jr target loaded
- branch_cnt  out  32  count of resolved conditional branches
- taken_cnt  out  32  count of resolved taken branches

## Operation

- Next-PC selection, highest priority first:
  1. reset: pc_f <= RESET_PC; addr_err, branch_cnt, taken_cnt <= 0.
  2. stall: pc_f, counters hold; addr_err <= 0; ID decision ignored (re-evaluated when stall drops).
  3. is_jr_d: pc_f <= {jr_target_d[31:2], 2'b00}; addr_err <= |jr_target_d[1:0].
  4. is_j_d: pc_f <= {pc4_d[31:28], index26_d, 2'b00}.
  5. is_branch_d && br_taken_d: pc_f <= pc4_d + {{14{imm16_d[15]}}, imm16_d, 2'b00}.
  6. otherwise: pc_f <= pc_f + 4.
- Multiple decode flags simultaneously asserted (illegal decode) resolve by the priority above; no error raised.
- All address arithmetic modulo 2^32; carries out of bit 31 discarded (wrap 32'hFFFF_FFFC + 4 -> 0).
- redirect = !stall && (is_jr_d || is_j_d || (is_branch_d && br_taken_d)); 0 during reset.
- Counters, on a non-stalled, non-reset cycle with is_branch_d=1: branch_cnt += 1; additionally taken_cnt += 1 if br_taken_d. Both wrap at 2^32. Counting occurs even if a higher-priority jump flag also wins.
- addr_err is 0 on every cycle except the one following a misaligned jr load.

## Timing

- Reset values: pc_f=RESET_PC, addr_err=0, branch_cnt=0, taken_cnt=0; pc4_f=RESET_PC+4 immediately.
- Single-cycle redirect latency: decision present in ID at edge N -> pc_f equals target after edge N.
- Delay slot: at edge N, IF holds the delay-slot instruction (pc_f = pc4_d); it proceeds normally; no flush output exists.
- Stall: any number of consecutive stall cycles leave pc_f unchanged; first non-stalled edge applies the ID decision then present.
- Reset asserted mid-redirect or mid-stall: RESET_PC loaded at that edge; pending decision discarded.
- No combinational path from inputs to pc_f; redirect and link_d are combinational.

## Test plan

- Reset: assert reset 2 cycles, release -> pc_f=0x3000, pc4_f=0x3004; 3 free edges -> pc_f=0x300C; counters 0.
- Taken branch: pc4_d=0x3008, imm16_d=0xFFFE, is_branch_d=1, br_taken_d=1 -> next pc_f=0x3000, redirect=1, branch_cnt=1, taken_cnt=1; not-taken repeat -> pc_f+=4, branch_cnt=2, taken_cnt=1.
- Jump: pc4_d=0x4000_3010, index26_d=0x0000C10, is_j_d=1 -> pc_f=0x4000_3040; with is_jr_d=1, jr_target_d=0x3102 same cycle -> jr wins, pc_f=0x3100, addr_err=1 next cycle only.
- Stall: taken branch with stall=1 for 3 cycles -> pc_f frozen, counters unchanged, redirect=0; stall drops -> target loaded, counters +1 once.
- Wrap: pc_f forced via jr to 0xFFFF_FFFC, free-run -> pc_f=0x0000_0000; branch with pc4_d=0xFFFF_FFF0, imm16_d=0x0008 -> pc_f=0x0000_0010.
- Reset mid-op: reset asserted same cycle as jr to 0x5000 -> pc_f=0x3000, addr_err=0.

Source files
------------

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: IF-stage program counter with single-delay-slot redirect.
// Picks the next fetch address from the ID-stage branch/jump decision, holds
// the PC through hazard stalls, flags misaligned register-jump targets, and
// counts resolved and taken conditional branches.
//
// Ports:
//   clk, reset          core clock, synchronous active-high reset
//   stall               freeze PC and counters this cycle
//   is_branch_d         ID holds a conditional branch
//   br_taken_d          branch comparator result (used only with is_branch_d)
//   is_j_d, is_jr_d     ID holds j/jal or jr/jalr
//   pc4_d               PC+4 of the ID instruction
//   imm16_d, index26_d  branch offset and jump index fields
//   jr_target_d         forwarded rs value for jr/jalr
//   pc_f                registered fetch address
//   pc4_f, link_d       pc_f+4 and pc4_d+4 (combinational)
//   redirect            next PC is not sequential (combinational)
//   addr_err            one-cycle pulse after a misaligned jr target load
//   branch_cnt          resolved conditional branches
//   taken_cnt           resolved taken branches
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        is_branch_d,
    input  logic        br_taken_d,
    input  logic        is_j_d,
    input  logic        is_jr_d,
    input  logic [31:0] pc4_d,
    input  logic [15:0] imm16_d,
    input  logic [25:0] index26_d,
    input  logic [31:0] jr_target_d,
    output logic [31:0] pc_f,
    output logic [31:0] pc4_f,
    output logic [31:0] link_d,
    output logic        redirect,
    output logic        addr_err,
    output logic [31:0] branch_cnt,
    output logic [31:0] taken_cnt
);

    localparam int unsigned XLEN = 32;

    logic [XLEN-1:0] br_offset;
    logic [XLEN-1:0] br_target;
    logic [XLEN-1:0] j_target;
    logic [XLEN-1:0] jr_target;
    logic [XLEN-1:0] pc_next;
    logic            br_take;
    logic            jr_misaligned;

    // Sequential and link addresses; carries out of bit 31 wrap naturally.
    assign pc4_f  = pc_f + XLEN'(4);
    assign link_d = pc4_d + XLEN'(4);

    // Candidate targets.
    assign br_offset     = {{14{imm16_d[15]}}, imm16_d, 2'b00};
    assign br_target     = pc4_d + br_offset;
    assign j_target      = {pc4_d[31:28], index26_d, 2'b00};
    assign jr_target     = {jr_target_d[31:2], 2'b00};
    assign jr_misaligned = |jr_target_d[1:0];
    assign br_take       = is_branch_d & br_taken_d;

    assign redirect = ~reset & ~stall & (is_jr_d | is_j_d | br_take);

    // Next-PC select; illegal multi-flag decodes resolve by priority.
    always_comb begin
        pc_next = pc4_f;
        if (is_jr_d) begin
            pc_next = jr_target;
        end else if (is_j_d) begin
            pc_next = j_target;
        end else if (br_take) begin
            pc_next = br_target;
        end
    end

    // PC register and misaligned-target pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f     <= RESET_PC;
            addr_err <= 1'b0;
        end else if (stall) begin
            addr_err <= 1'b0;
        end else begin
            pc_f     <= pc_next;
            addr_err <= is_jr_d & jr_misaligned;
        end
    end

    // Branch statistics; a branch is counted even when a jump flag wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            branch_cnt <= '0;
            taken_cnt  <= '0;
        end else if (!stall && is_branch_d) begin
            branch_cnt <= branch_cnt + XLEN'(1);
            if (br_taken_d) begin
                taken_cnt <= taken_cnt + XLEN'(1);
            end
        end
    end

endmodule
